// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, instruction field positions,
// fetch FSM state encodings and the default reset PC.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Field layout of the 16-bit instruction word
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 10;
  localparam int RS_MSB     = 9;
  localparam int RS_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/program_counter.sv
// Program counter register with jump load, increment and async reset.
// Exposes both the current pc and pc+1 (modulo 2^PC_W).
module program_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  assign pc_inc = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: requests instructions over req/ack, latches them in the IR and
// presents decoded fields to the control unit over valid/ready.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [7:0]         imm,
  output logic [PC_W-1:0]    pc_out,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  output logic               halted,
  output logic [1:0]         fsm_state
);

  logic [1:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_inc;
  logic               fetch_done;
  logic               accept;
  logic               is_halt;
  logic               pc_load;

  // Handshakes: imem_req stays high with a stable imem_addr until a cycle with
  // imem_ack=1; instr_valid stays high with stable fields until a cycle with
  // instr_ready=1, and that cycle is the only one in which jump_taken is used.
  assign fetch_done = (state == ST_FETCH) && imem_ack;
  assign accept     = (state == ST_HOLD) && instr_ready;
  assign is_halt    = (opcode == OP_HALT);
  assign pc_load    = accept && !is_halt && jump_taken;

  program_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (jump_target),
    .inc      (fetch_done),
    .pc       (pc),
    .pc_inc   (pc_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ir     <= '0;
      pc_out <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            ir     <= imem_rdata;
            pc_out <= pc;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            state <= is_halt ? ST_HALT : ST_FETCH;
          end
        end
        default:  state <= ST_HALT;
      endcase
    end
  end

  // The pc already points at the next instruction once the IR is loaded, so
  // a redirect never leaves a wrong-path request behind.
  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);
  assign halted      = (state == ST_HALT);
  assign fsm_state   = state;

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model plus an architectural reference
// (next pc = halt ? stop : jump ? target : pc+1) driven with random wait states.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [3:0]  opcode;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic [7:0]  pc_out;
  logic        jump_taken = 1'b0;
  logic [7:0]  jump_target = '0;
  logic        halted;
  logic [1:0]  fsm_state;

  logic [15:0] mem [0:255];
  logic [7:0]  model_pc;
  logic        model_halted;
  int          checks = 0;
  int          fails = 0;

  localparam logic [33:0] RESET_OBS = 34'h0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .pc_out      (pc_out),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .halted      (halted),
    .fsm_state   (fsm_state)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] reset_obs();
    return {imem_req, imem_addr, instr_valid, halted, opcode, rd, rs, imm, pc_out};
  endfunction

  // One full instruction: FETCH with ack_dly wait cycles, HOLD with rdy_dly
  // stall cycles, then accept with the given redirect request.
  task automatic do_instr(input int ack_dly, input int rdy_dly,
                          input logic jt, input logic [7:0] tgt);
    logic [15:0] word;
    logic [25:0] exp_hold;
    word = mem[model_pc];
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, model_pc}) begin
      fails++;
      $display("FAIL fetch_start: req=%b valid=%b addr=%h, required req=1 valid=0 addr=%h",
               imem_req, instr_valid, imem_addr, model_pc);
    end
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
      jump_taken = 1'b1; jump_target = 8'($urandom);
      instr_ready = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, model_pc}) begin
        fails++;
        $display("FAIL fetch_wait: req=%b valid=%b addr=%h, required req=1 valid=0 addr=%h",
                 imem_req, instr_valid, imem_addr, model_pc);
      end
    end
    imem_ack = 1'b1; imem_rdata = word;
    jump_taken = 1'b1; jump_target = 8'($urandom); instr_ready = 1'b0;
    cycle();
    exp_hold = {1'b1, 1'b0, word, model_pc};
    for (int i = 0; i <= rdy_dly; i++) begin
      checks++;
      if ({instr_valid, imem_req, opcode, rd, rs, imm, pc_out} !== exp_hold) begin
        fails++;
        $display("FAIL hold_fields: valid=%b req=%b op=%h rd=%h rs=%h imm=%h pc_out=%h, required %h",
                 instr_valid, imem_req, opcode, rd, rs, imm, pc_out, exp_hold);
      end
      if (i < rdy_dly) begin
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
        jump_taken = 1'b1; jump_target = 8'($urandom); instr_ready = 1'b0;
        cycle();
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b1; jump_taken = jt; jump_target = tgt;
    cycle();
    instr_ready = 1'b0; jump_taken = 1'b0;
    if (word[15:12] == 4'hF) model_halted = 1'b1;
    else model_pc = jt ? tgt : 8'(model_pc + 8'd1);
    checks++;
    if ({imem_req, instr_valid, halted} !== {!model_halted, 1'b0, model_halted} ||
        (!model_halted && imem_addr !== model_pc)) begin
      fails++;
      $display("FAIL after_accept: req=%b valid=%b halted=%b addr=%h, required req=%b valid=0 halted=%b addr=%h",
               imem_req, instr_valid, halted, imem_addr, !model_halted, model_halted, model_pc);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_pc = 8'h00; model_halted = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_cycle: req=%b, required 0", imem_req);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    checks++;
    if (reset_obs() !== RESET_OBS) begin
      fails++;
      $display("FAIL reset_values: got %h, required %h", reset_obs(), RESET_OBS);
    end
    release_reset();
    do_instr(0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_ack_delay();
    do_instr(3, 0, 1'b0, 8'h00);
  endtask

  task automatic test_ready_stall();
    do_instr(0, 5, 1'b0, 8'h00);
  endtask

  task automatic test_jump();
    mem[model_pc] = 16'h6040;
    do_instr(2, 2, 1'b1, 8'h40);
    do_instr(1, 0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    mem[model_pc] = 16'h60FF;
    do_instr(0, 0, 1'b1, 8'hFF);
    mem[8'hFF] = 16'h1234;
    do_instr(1, 0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30 && !model_halted; n++) begin
      do_instr($urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  task automatic test_halt();
    mem[model_pc] = 16'hF000;
    do_instr(0, 1, 1'b1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); instr_ready = 1'($urandom_range(0, 1));
      jump_taken = 1'($urandom_range(0, 1)); jump_target = 8'($urandom);
      cycle();
      checks++;
      if ({halted, imem_req, instr_valid} !== 3'b100) begin
        fails++;
        $display("FAIL halt_sticky: halted=%b req=%b valid=%b, required 1 0 0",
                 halted, imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b0; jump_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (reset_obs() !== RESET_OBS) begin
      fails++;
      $display("FAIL reset_in_halt: got %h, required %h", reset_obs(), RESET_OBS);
    end
    cycle();
    release_reset();
  endtask

  task automatic test_reset_mid_fetch();
    mem[0] = 16'h0123;
    imem_ack = 1'b0;
    cycle();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL pending_fetch: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (reset_obs() !== RESET_OBS) begin
      fails++;
      $display("FAIL reset_in_fetch: got %h, required %h", reset_obs(), RESET_OBS);
    end
    repeat (2) cycle();
    release_reset();
    do_instr(0, 0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = 16'($urandom);
      if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'h0;
    end
    mem[0] = 16'h0123;
    model_pc = 8'h00;
    model_halted = 1'b0;
    test_reset();
    test_ack_delay();
    test_ready_stall();
    test_jump();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Front-end stage of the 8-bit CPU. Holds the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and latches them in an instruction register. It splits each instruction into fields and offers them to the control unit over a valid/ready handshake. Jump redirects and HALT are applied when an instruction is accepted.

## Interface
- PC_W, 8, program counter and instruction-memory address width
- INSTR_W, 16, instruction width; fixed field layout assumes 16
- RESET_PC, 8'h00, PC value after reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address, stable while imem_req=1
- imem_ack  in  1  memory has valid data on imem_rdata this cycle
- imem_rdata  in  INSTR_W  instruction word
- instr_valid  out  1  decoded fields valid
- instr_ready  in  1  downstream accepts the instruction this cycle
- opcode  out  4  instr[15:12], feeds control unit
- rd  out  2  instr[11:10]
- rs  out  2  instr[9:8]
- imm  out  8  instr[7:0], immediate or memory/jump address
- pc_out  out  PC_W  address the presented instruction was fetched from
- jump_taken  in  1  redirect request, sampled only on the accept cycle
- jump_target  in  PC_W  redirect destination
- halted  out  1  core stopped after HALT

## Operation
- FSM states: IDLE, FETCH, HOLD, HALT. Reset state is IDLE.
- IDLE: all outputs inactive. Moves to FETCH unconditionally on the next clock.
- FETCH: imem_req=1, imem_addr=pc.
  - When imem_ack=1, capture imem_rdata into the IR, set pc_out<=pc and pc<=pc+1, then go to HOLD.
  - pc+1 is modulo 2^PC_W, so 8'hFF wraps to 8'h00.
- HOLD: instr_valid=1. Fields and pc_out stay stable until accepted.
- Accept happens when instr_valid & instr_ready. On accept, priority is:
  1. opcode==4'hF (HALT): go to HALT. jump_taken is ignored.
  2. jump_taken=1: pc<=jump_target, go to FETCH.
  3. Otherwise: go to FETCH with the already-incremented pc.
- HALT: halted=1. imem_req=0 and instr_valid=0. Only reset leaves HALT.
- imem_ack outside FETCH is ignored. jump_taken outside the accept cycle is ignored.
- All outputs are registered or pure Moore decodes of state. No combinational path from any input to any output.

## Timing
- Reset values while rst_n=0:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, halted=0
  - opcode/rd/rs/imm=0, pc_out=0
  - pc=RESET_PC, state IDLE
- Reset applied mid-operation aborts any outstanding request immediately. Memory must tolerate req dropping without an ack.
- First imem_req=1 appears in the second cycle after rst_n deasserts (IDLE lasts one cycle).
- Ack sampled at edge N gives instr_valid=1 from edge N.
- Best case, with ack in the first FETCH cycle and ready held at 1, is 2 cycles per instruction.
- Wait states: each extra cycle of ack delay or ready delay adds exactly one cycle.
- Redirect: the first request to jump_target is issued in the cycle after the accept. No wrong-path fetch is ever issued.

## Structure
- Shared cpu_pkg holds:
  - opcode constants (ADD..JUMP = 4'h0..4'h6, HALT = 4'hF)
  - field bit positions
  - FSM state enum
  - RESET_PC default
- Control unit imports the same opcode constants.
- One natural sub-module: program_counter. It holds the PC register with load (jump), increment and async reset, and exposes pc and pc+1.
- The FSM, IR and field split stay in instr_fetch.

## Test plan
- Reset release, memory returns 16'h0123 at address 0 with zero wait, ready=1:
  - imem_req rises in the 2nd cycle after reset.
  - instr_valid follows with opcode=0, rd=0, rs=1, imm=8'h23, pc_out=0.
  - Next imem_addr=1.
- Ack delayed 3 cycles:
  - imem_addr is held constant and imem_req stays high for 4 cycles.
  - instr_valid rises one cycle after ack.
- instr_ready low for 5 cycles in HOLD:
  - fields and pc_out stay stable.
  - no new imem_req is issued.
  - a fetch resumes the cycle after ready=1.
- JUMP 16'h6040 accepted with jump_taken=1, jump_target=8'h40:
  - next imem_addr=8'h40.
  - jump_taken pulsed outside the accept cycle has no effect.
- PC wrap: instruction fetched at 8'hFF, no jump → next imem_addr=8'h00.
- HALT 16'hF000 accepted with jump_taken=1:
  - halted=1, imem_req stays 0, jump ignored.
  - asserting rst_n=0 mid-HALT, or mid-FETCH with ack pending, returns all outputs to reset values immediately.
